// File: rtl/tspi_rx_rxd_pkg.sv
// Shared constants and FSM encoding for the SPI receive deserializer.
package tspi_rx_rxd_pkg;
  localparam int DATA_W      = 8;
  localparam int CFG_W       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int BCNT_W      = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/tspi_rx_rxd_shift.sv
// SCLK/MOSI synchronizers, rising-edge detect and MSB-first shift register.
// The bit counter is held clear whenever shift_en is low, so a partial word is dropped.
module tspi_rx_rxd_shift
  import tspi_rx_rxd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              shift_en,
  output logic              sclk_rise,
  output logic              word_done,
  output logic [DATA_W-1:0] word_dat
);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [BCNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                   mosi_bit;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
    // MOSI is taken from the same stage as the edge it is sampled on.
    mosi_bit    = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_done   = 1'b0;
    if (!shift_en) begin
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      shreg_d = {shreg_q[DATA_W-2:0], mosi_bit};
      if (bit_cnt_q == BIT_LAST) begin
        word_done = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    word_dat = shreg_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/tspi_rx_rxd.sv
// SPI receive deserializer top: frame FSM, word counter and handshake outputs.
// Optional idle timeout abort is built when TSPI_RX_TIMEOUT_EN is defined.
module tspi_rx_rxd
  import tspi_rx_rxd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd_en,
  output logic              rxd_cmpt,
  input  logic [CFG_W-1:0]  rx_len,
  input  logic [CFG_W-1:0]  rx_timeout,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err,
  input  logic              SCLK,
  input  logic              MOSI
);
  state_t              state_q, state_d;
  logic [CFG_W-1:0]    len_q, len_d;
  logic [CFG_W-1:0]    word_cnt_q, word_cnt_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_err_q, rx_err_d;
  logic                shift_en, sclk_rise, word_done;
  logic [DATA_W-1:0]   word_dat;
`ifdef TSPI_RX_TIMEOUT_EN
  logic [CFG_W-1:0]    tmo_q, tmo_d;
  logic [CFG_W-1:0]    idle_cnt_q, idle_cnt_d;
`else
  logic                unused_tmo;
  assign unused_tmo = ^rx_timeout;
`endif

  tspi_rx_rxd_shift u_shift (
    .clk       (clk),
    .rst       (rst),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .shift_en  (shift_en),
    .sclk_rise (sclk_rise),
    .word_done (word_done),
    .word_dat  (word_dat)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_err_d   = 1'b0;
    shift_en   = 1'b0;
`ifdef TSPI_RX_TIMEOUT_EN
    tmo_d      = tmo_q;
    idle_cnt_d = idle_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rxd_en) begin
          len_d      = rx_len;
          word_cnt_d = '0;
          state_d    = (rx_len == '0) ? DONE : RECV;
`ifdef TSPI_RX_TIMEOUT_EN
          tmo_d      = rx_timeout;
          idle_cnt_d = '0;
`endif
        end
      end
      RECV: begin
        shift_en = 1'b1;
        // Compare the registered count so DONE lands one cycle after the last rx_valid.
        if (word_cnt_q == len_q) begin
          state_d = DONE;
        end else begin
          if (word_done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = word_dat;
            word_cnt_d = word_cnt_q + 1'b1;
          end
`ifdef TSPI_RX_TIMEOUT_EN
          if (sclk_rise) begin
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
            if ((tmo_q != '0) && (idle_cnt_d == tmo_q)) begin
              rx_err_d = 1'b1;
              state_d  = IDLE;
            end
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
`ifdef TSPI_RX_TIMEOUT_EN
      tmo_q      <= '0;
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
`ifdef TSPI_RX_TIMEOUT_EN
      tmo_q      <= tmo_d;
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign rxd_cmpt = (state_q == DONE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
endmodule
